floor_call_encoder: RTL and testbench
=====================================

// Module: floor_call_encoder
// PURPOSE
//  Input-side counterpart of the floor 7-segment display path: turns raw hall/car call buttons into
//  one-hot floor requests for the elevator controller. Per-button sync/debounce, latched pending
//  calls, rotating-priority selection, valid/ready offer to the controller. Uses the same
//  one-hot floor[8:1] encoding (bit n = floor n) consumed by the display decoder.
// PARAMETERS
//  NFLOORS    8   number of floors; one bit per floor, index 1..NFLOORS
//  DB_CYCLES  16  consecutive stable-high samples needed to accept a press (>=2)
//  CNT_W      5   debounce counter width; must hold DB_CYCLES
// PORTS
//  clk        in   1        single system clock; all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  btn        in   [8:1]    raw asynchronous call buttons, active-high, bit n = floor n
//  cur_floor  in   [8:1]    one-hot current cabin floor from controller
//  served     in   1        1-cycle pulse: controller has served cur_floor (doors opened)
//  req_floor  out  [8:1]    one-hot offered request; 8'b0 when req_valid=0
//  req_valid  out  1        offer valid
//  req_ready  in   1        controller accepts offer this cycle
//  pending    out  [8:1]    all latched, not-yet-served calls (for call-lamp LEDs)
// BEHAVIOUR
//  Reset: pending=0, accepted=0, req_floor=0, req_valid=0, debounce counters=0, sync flops=0,
//   FSM=IDLE, last_grant=8'b1000_0000 (first search starts at floor 1). Reset mid-offer drops it.
//  Input path per bit: 2-flop synchronizer -> counter; counts up while synced=1, clears when 0;
//   debounced level=1 when count reaches DB_CYCLES (saturates). Rising edge of debounced level
//   sets pending[n]. Press-to-pending latency = 2 + DB_CYCLES + 1 cycles. Holding a button sets once.
//  Clear: served=1 and cur_floor exactly one-hot -> clear pending and accepted bits at that floor.
//   served with cur_floor zero or multi-hot: ignored. Set and clear on same bit same cycle: clear wins.
//  accepted[8:1]: calls handed to controller; never re-offered until cleared by served.
//  Candidates = pending & ~accepted.
//  FSM IDLE: if candidates!=0, select first candidate scanning upward from floor after last_grant,
//   wrapping 8->1; register req_floor, req_valid=1, go OFFER next cycle. Else stay.
//  FSM OFFER: req_floor/req_valid held stable while req_ready=0.
//   req_ready=1 -> accepted|=req_floor, last_grant=req_floor, req_valid=0 next cycle, -> IDLE.
//   Offered bit cleared by served while waiting (and req_ready=0) -> withdraw: req_valid=0 next
//   cycle, -> IDLE (only permitted valid drop). req_ready and clear same cycle: accept, bit cleared.
//  Selection to next offer: min 1 idle cycle between offers (IDLE->OFFER registered).
//  req_ready ignored when req_valid=0. New presses during OFFER only latch into pending.
//  All outputs registered; no combinational path from btn/req_ready to outputs.
// STRUCTURE
//  elevator.svh: NFLOORS, one-hot constants FLOOR_1..FLOOR_8, FSM state localparams ST_IDLE/ST_OFFER,
//   shared with display decoder and controller.
//  Sub-module btn_debounce (sync + counter + edge detect, one bit, params DB_CYCLES/CNT_W),
//   instantiated NFLOORS times via generate; top holds pending/accepted regs, rotate-select, FSM.
// TESTING
//  1 Reset: assert rst 2 cycles -> req_valid=0, req_floor=0, pending=0 on all following cycles until press.
//  2 Debounce: btn[3] high 10 cycles (DB_CYCLES=16) -> pending stays 0; high 20 cycles -> pending=8'b0000_0100
//    exactly 19 cycles after first high sample; req_valid rises next cycle with req_floor=8'b0000_0100.
//  3 Rotation: last_grant=floor 5, pending floors 2 and 7 -> offer 7 first; accept; then offer 2 (wrap).
//  4 Backpressure: req_ready=0 for 50 cycles with new press on floor 1 meanwhile -> req_floor constant,
//    pending gains bit 1; req_ready=1 -> accepted, floor 1 offered after.
//  5 Withdraw/clear-wins: offer floor 4 pending, served with cur_floor=8'b0000_1000 -> req_valid=0 next
//    cycle, pending[4]=0; same-cycle new edge on floor 4 with served -> pending[4]=0.
//  6 Bad cur_floor: served with cur_floor=8'b0001_0100 or 0 -> pending unchanged.

Source files
------------

// File: rtl/floor_call_encoder_pkg.sv
// rtl/floor_call_encoder_pkg.sv - shared floor encoding, FSM states and selection helpers
package floor_call_encoder_pkg;

    localparam int NFLOORS = 8;

    localparam logic [NFLOORS:1] FLOOR_1 = 8'b0000_0001;
    localparam logic [NFLOORS:1] FLOOR_2 = 8'b0000_0010;
    localparam logic [NFLOORS:1] FLOOR_3 = 8'b0000_0100;
    localparam logic [NFLOORS:1] FLOOR_4 = 8'b0000_1000;
    localparam logic [NFLOORS:1] FLOOR_5 = 8'b0001_0000;
    localparam logic [NFLOORS:1] FLOOR_6 = 8'b0010_0000;
    localparam logic [NFLOORS:1] FLOOR_7 = 8'b0100_0000;
    localparam logic [NFLOORS:1] FLOOR_8 = 8'b1000_0000;

    localparam logic [NFLOORS:1] ONE_V          = NFLOORS'(1);
    localparam logic [NFLOORS:1] LAST_GRANT_RST = {1'b1, {(NFLOORS-1){1'b0}}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    function automatic logic is_onehot(input logic [NFLOORS:1] v);
        return (v != '0) && ((v & (v - ONE_V)) == '0);
    endfunction

    function automatic logic [NFLOORS:1] lowest_set(input logic [NFLOORS:1] v);
        return v & (~v + ONE_V);
    endfunction

    // First candidate strictly above last (one-hot), wrapping to the lowest floor.
    // For last at the top floor, (last << 1) overflows to zero and the upper mask is empty.
    function automatic logic [NFLOORS:1] rotate_pick(input logic [NFLOORS:1] cand,
                                                     input logic [NFLOORS:1] last);
        logic [NFLOORS:1] upto;
        logic [NFLOORS:1] above;
        upto  = (last << 1) - ONE_V;
        above = cand & ~upto;
        return (above != '0) ? lowest_set(above) : lowest_set(cand);
    endfunction

endpackage

// File: rtl/floor_call_encoder_btn_debounce.sv
// rtl/floor_call_encoder_btn_debounce.sv - one-button synchronizer, debounce counter and press-edge pulse
module btn_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            db_q      <= (cnt_q == CNT_MAX);
            db_prev_q <= db_q;
        end
    end

    // Single pulse per accepted press; a held button stays at db_q=1 and does not retrigger.
    assign rise_o = db_q & ~db_prev_q;

endmodule

// File: rtl/floor_call_encoder.sv
// rtl/floor_call_encoder.sv - latches debounced call buttons and offers them one-hot with rotating priority
module floor_call_encoder
    import floor_call_encoder_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS:1]   btn,
    input  logic [NFLOORS:1]   cur_floor,
    input  logic               served,
    output logic [NFLOORS:1]   req_floor,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [NFLOORS:1]   pending
);

    logic [NFLOORS:1] rise_vec;
    logic [NFLOORS:1] clr_vec;
    logic [NFLOORS:1] cand;
    logic [NFLOORS:1] pick;

    logic [NFLOORS:1] pending_q,    pending_d;
    logic [NFLOORS:1] accepted_q,   accepted_d;
    logic [NFLOORS:1] req_floor_q,  req_floor_d;
    logic             req_valid_q,  req_valid_d;
    logic [NFLOORS:1] last_grant_q, last_grant_d;
    logic [NFLOORS:1] accept_vec;
    state_e           state_q,      state_d;

    for (genvar g = 1; g <= NFLOORS; g++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn[g]),
            .rise_o (rise_vec[g])
        );
    end

    // A serve report only counts when it names exactly one floor.
    assign clr_vec = (served && is_onehot(cur_floor)) ? cur_floor : '0;
    assign cand    = pending_q & ~accepted_q & ~clr_vec;
    assign pick    = rotate_pick(cand, last_grant_q);

    always_comb begin
        state_d      = state_q;
        req_floor_d  = req_floor_q;
        req_valid_d  = req_valid_q;
        last_grant_d = last_grant_q;
        accept_vec   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (cand != '0) begin
                    req_floor_d = pick;
                    req_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (req_ready) begin
                    accept_vec   = req_floor_q;
                    last_grant_d = req_floor_q;
                    req_floor_d  = '0;
                    req_valid_d  = 1'b0;
                    state_d      = ST_IDLE;
                end else if ((req_floor_q & clr_vec) != '0) begin
                    req_floor_d = '0;
                    req_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                req_floor_d = '0;
                req_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Clear is applied last so it wins over a same-cycle press or accept.
        pending_d  = (pending_q | rise_vec) & ~clr_vec;
        accepted_d = (accepted_q | accept_vec) & ~clr_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            accepted_q   <= '0;
            req_floor_q  <= '0;
            req_valid_q  <= 1'b0;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            accepted_q   <= accepted_d;
            req_floor_q  <= req_floor_d;
            req_valid_q  <= req_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req_floor = req_floor_q;
    assign req_valid = req_valid_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_floor_call_encoder.sv
// tb/tb_floor_call_encoder.sv - directed bench with cycle-level reference model for floor_call_encoder
module tb_floor_call_encoder;

    localparam int DB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:1] btn;
    logic [8:1] cur_floor;
    logic       served;
    logic [8:1] req_floor;
    logic       req_valid;
    logic       req_ready;
    logic [8:1] pending;

    int n_checks = 0;
    int n_fail   = 0;

    floor_call_encoder #(.DB_CYCLES(DB), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .cur_floor (cur_floor),
        .served    (served),
        .req_floor (req_floor),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:1] act, input logic [8:1] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: press accepted when the button has been seen high for DB
    // consecutive cycles; it lands in pending four edges after that DB-th sample.
    int         run [1:8];
    logic [8:1] ev_dly [4];
    logic [8:1] m_pend, m_acc, m_floor;
    logic       m_valid;
    int         m_last;
    bit         model_live = 0;

    always @(posedge clk) begin : model_step
        logic [8:1] new_ev, rise_now, clr, cand, nacc;
        int idx;
        if (rst) begin
            for (int n = 1; n <= 8; n++) run[n] = 0;
            for (int i = 0; i < 4; i++) ev_dly[i] = '0;
            m_pend = '0; m_acc = '0; m_floor = '0; m_valid = 0; m_last = 8;
            model_live = 1;
        end else begin
            for (int n = 1; n <= 8; n++) begin
                if (btn[n]) run[n]++; else run[n] = 0;
                new_ev[n] = (run[n] == DB);
            end
            rise_now  = ev_dly[3];
            ev_dly[3] = ev_dly[2];
            ev_dly[2] = ev_dly[1];
            ev_dly[1] = ev_dly[0];
            ev_dly[0] = new_ev;
            clr  = (served && $countones(cur_floor) == 1) ? cur_floor : 8'b0;
            cand = m_pend & ~m_acc & ~clr;
            nacc = m_acc;
            if (m_valid) begin
                if (req_ready) begin
                    nacc = nacc | m_floor;
                    for (int k = 1; k <= 8; k++) if (m_floor[k]) m_last = k;
                    m_valid = 0; m_floor = '0;
                end else if ((m_floor & clr) != 0) begin
                    m_valid = 0; m_floor = '0;
                end
            end else if (cand != 0) begin
                for (int k = 1; k <= 8; k++) begin
                    idx = (m_last + k - 1) % 8 + 1;
                    if (cand[idx]) begin
                        m_floor = '0; m_floor[idx] = 1'b1; m_valid = 1;
                        break;
                    end
                end
            end
            m_pend = (m_pend | rise_now) & ~clr;
            m_acc  = nacc & ~clr;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("model_req_valid", {7'b0, req_valid}, {7'b0, m_valid});
            chk("model_req_floor", req_floor, m_floor);
            chk("model_pending",   pending,   m_pend);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [8:1] m, input int n);
        btn = m;
        tick(n);
        btn = '0;
    endtask

    task automatic wait_valid(input int max);
        int c = 0;
        while (!req_valid && c < max) begin
            tick(1);
            c++;
        end
        chk("wait_valid", {7'b0, req_valid}, 8'd1);
    endtask

    task automatic accept();
        req_ready = 1'b1;
        tick(1);
        req_ready = 1'b0;
    endtask

    task automatic serve(input logic [8:1] f);
        cur_floor = f;
        served    = 1'b1;
        tick(1);
        served    = 1'b0;
        cur_floor = '0;
    endtask

    initial begin
        rst = 1'b1; btn = '0; cur_floor = '0; served = 1'b0; req_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_valid",   {7'b0, req_valid}, 8'd0);
        chk("rst_floor",   req_floor, 8'b0);
        chk("rst_pending", pending,   8'b0);
        tick(5);
        chk("idle_pending", pending, 8'b0);

        // Debounce: short press rejected, long press latched 19 cycles after first sample
        press(8'b0000_0100, 10);
        tick(30);
        chk("short_press", pending, 8'b0);
        btn = 8'b0000_0100;
        tick(19);
        chk("pre_latency", pending, 8'b0);
        tick(1);
        chk("latency_pending", pending, 8'b0000_0100);
        chk("latency_novalid", {7'b0, req_valid}, 8'd0);
        tick(1);
        btn = '0;
        chk("first_valid", {7'b0, req_valid}, 8'd1);
        chk("first_floor", req_floor, 8'b0000_0100);
        accept();
        chk("after_accept", {7'b0, req_valid}, 8'd0);
        tick(3);
        chk("no_reoffer", {7'b0, req_valid}, 8'd0);
        serve(8'b0000_0100);
        chk("served3", pending, 8'b0);

        // Rotation: last grant 5, pending 2 and 7
        press(8'b0001_0000, 20);
        wait_valid(10);
        chk("offer5", req_floor, 8'b0001_0000);
        accept();
        serve(8'b0001_0000);
        press(8'b0100_0010, 20);
        wait_valid(10);
        chk("rot_offer7", req_floor, 8'b0100_0000);
        accept();
        chk("gap_after7", {7'b0, req_valid}, 8'd0);
        wait_valid(5);
        chk("rot_offer2", req_floor, 8'b0000_0010);
        accept();
        chk("rot_pending", pending, 8'b0100_0010);
        serve(8'b0100_0000);
        serve(8'b0000_0010);

        // Backpressure with a press arriving mid-offer
        press(8'b0010_0000, 20);
        wait_valid(10);
        btn = 8'b0000_0001;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) btn = '0;
            tick(1);
            chk("bp_floor_stable", req_floor, 8'b0010_0000);
        end
        chk("bp_pending", pending, 8'b0010_0001);
        accept();
        chk("bp_gap", {7'b0, req_valid}, 8'd0);
        tick(1);
        chk("bp_offer1_valid", {7'b0, req_valid}, 8'd1);
        chk("bp_offer1_floor", req_floor, 8'b0000_0001);
        accept();
        serve(8'b0010_0000);
        serve(8'b0000_0001);

        // Withdraw on serve, then clear beats a same-cycle new press edge
        press(8'b0000_1000, 20);
        wait_valid(10);
        chk("offer4", req_floor, 8'b0000_1000);
        serve(8'b0000_1000);
        chk("withdraw_valid", {7'b0, req_valid}, 8'd0);
        chk("withdraw_pending", pending, 8'b0);
        btn = 8'b0000_1000;
        tick(19);
        cur_floor = 8'b0000_1000;
        served    = 1'b1;
        tick(1);
        served = 1'b0; cur_floor = '0; btn = '0;
        chk("clear_wins", pending, 8'b0);
        tick(2);
        chk("clear_wins_novalid", {7'b0, req_valid}, 8'd0);

        // Malformed serve reports are ignored
        press(8'b1000_0000, 20);
        wait_valid(10);
        chk("offer8", req_floor, 8'b1000_0000);
        accept();
        serve(8'b0001_0100);
        chk("bad_multihot", pending, 8'b1000_0000);
        serve(8'b0000_0000);
        chk("bad_zero", pending, 8'b1000_0000);
        serve(8'b1000_0000);
        chk("good_serve8", pending, 8'b0);

        // Reset during an offer drops it
        press(8'b0000_0010, 20);
        wait_valid(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_valid",   {7'b0, req_valid}, 8'd0);
        chk("midrst_pending", pending, 8'b0);
        tick(25);
        chk("midrst_stays", {7'b0, req_valid}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
